gate_array_reg: RTL and testbench

//  Parametrised, registered successor to the 2/3/4-input gate cells: one N-input, W-bit-wide

---
 rtl/gate_array_reg_if.sv | 45 ++++
 rtl/gate_array_reg.sv | 118 +++++++++++
 tb/tb_gate_array_reg.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_array_reg_if.sv
// ============================================================================
//  gate_array_reg_if : handshake bundle for gate_array_reg (input + output side)
//  op_cnt and CNT_W exist only when GATE_OPCNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

interface gate_array_reg_if #(
   parameter int N = 2,
   parameter int W = 1
`ifdef GATE_OPCNT_EN
 , parameter int CNT_W = 16
`endif
);
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         op;
   logic [N*W-1:0]     a;
   logic [N-1:0]       en_mask;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       f;
   logic [2:0]         out_op;
`ifdef GATE_OPCNT_EN
   logic [CNT_W-1:0]   op_cnt;
`endif

   // master = producer + consumer of the stage, slave = the gate stage itself
   modport master (
      output in_valid, op, a, en_mask, out_ready,
      input  in_ready, out_valid, f, out_op
`ifdef GATE_OPCNT_EN
    , input  op_cnt
`endif
   );

   modport slave (
      input  in_valid, op, a, en_mask, out_ready,
      output in_ready, out_valid, f, out_op
`ifdef GATE_OPCNT_EN
    , output op_cnt
`endif
   );
endinterface

`default_nettype wire

// File: rtl/gate_array_reg.sv
// ============================================================================
//  gate_array_reg : N-input, W-bit registered gate with runtime op and mask.
//  Optional saturating op_cnt under GATE_OPCNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module gate_array_reg #(
   parameter int N     = 2,
   parameter int W     = 1,
   parameter int CNT_W = 16
) (
   input  wire               clk,
   input  wire               rst_n,
   gate_array_reg_if.slave   bus
);

   localparam logic [2:0] C_OP_AND  = 3'b000;
   localparam logic [2:0] C_OP_OR   = 3'b001;
   localparam logic [2:0] C_OP_NAND = 3'b010;
   localparam logic [2:0] C_OP_NOR  = 3'b011;
   localparam logic [2:0] C_OP_XOR  = 3'b100;
   localparam logic [2:0] C_OP_XNOR = 3'b101;
   localparam logic [2:0] C_OP_INV  = 3'b110;

   generate
      if (N < 1 || N > 8 || W < 1 || W > 64 || CNT_W < 1) begin : g_bad_params
         $error("gate_array_reg: illegal N/W/CNT_W");
      end
   endgenerate

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     f_q, f_d;
   logic [2:0]       out_op_q, out_op_d;
   logic             accept;
   logic [W-1:0]     red_and, red_or, red_xor, gate_res;

   // Masked channels fold in as the identity of each reduction
   always_comb begin
      red_and = '1;
      red_or  = '0;
      red_xor = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.en_mask[i]) begin
            red_and = red_and & bus.a[i*W +: W];
            red_or  = red_or  | bus.a[i*W +: W];
            red_xor = red_xor ^ bus.a[i*W +: W];
         end
      end
   end

   always_comb begin
      case (bus.op)
         C_OP_AND:  gate_res = red_and;
         C_OP_OR:   gate_res = red_or;
         C_OP_NAND: gate_res = ~red_and;
         C_OP_NOR:  gate_res = ~red_or;
         C_OP_XOR:  gate_res = red_xor;
         C_OP_XNOR: gate_res = ~red_xor;
         C_OP_INV:  gate_res = ~bus.a[W-1:0];
         default:   gate_res = bus.a[W-1:0];
      endcase
   end

   // Ready looks through the register so a draining result never costs a bubble
   assign bus.in_ready = ~out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      f_d         = f_q;
      out_op_d    = out_op_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         f_d         = gate_res;
         out_op_d    = bus.op;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         f_q         <= '0;
         out_op_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         f_q         <= f_d;
         out_op_q    <= out_op_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.f         = f_q;
   assign bus.out_op    = out_op_q;

`ifdef GATE_OPCNT_EN
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

   always_comb begin
      op_cnt_d = op_cnt_q;
      if (accept && (op_cnt_q != {CNT_W{1'b1}}))
         op_cnt_d = op_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op_cnt_q <= '0;
      else
         op_cnt_q <= op_cnt_d;
   end

   assign bus.op_cnt = op_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_array_reg.sv
// ============================================================================
//  tb_gate_array_reg : self-checking bench for gate_array_reg (N=4, W=8).
//  Covers the op_cnt path when GATE_OPCNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_array_reg;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   gate_array_reg_if #(
      .N(N), .W(W)
`ifdef GATE_OPCNT_EN
    , .CNT_W(CNT_W)
`endif
   ) bus ();

   gate_array_reg #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Bit-by-bit model: count the enabled channels and how many of them carry a 1
   function automatic logic [W-1:0] ref_gate(input logic [2:0] op,
                                              input logic [N*W-1:0] a,
                                              input logic [N-1:0] m);
      logic [W-1:0] r;
      int ones, en;
      r = '0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         en   = 0;
         for (int c = 0; c < N; c++) begin
            if (m[c]) begin
               en++;
               if (a[c*W + b]) ones++;
            end
         end
         case (op)
            3'd0: r[b] = (ones == en);
            3'd1: r[b] = (ones != 0);
            3'd2: r[b] = (ones != en);
            3'd3: r[b] = (ones == 0);
            3'd4: r[b] = (ones % 2) == 1;
            3'd5: r[b] = (ones % 2) == 0;
            3'd6: r[b] = ~a[b];
            default: r[b] = a[b];
         endcase
      end
      return r;
   endfunction

   task automatic apply_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.en_mask   = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (bus.out_valid !== 1'b0 || bus.f !== '0 || bus.out_op !== 3'd0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: got v=%b f=%h op=%h rdy=%b, want v=0 f=00 op=0 rdy=1",
                  bus.out_valid, bus.f, bus.out_op, bus.in_ready);
      end
      // Load a result, stall it, then yank reset mid-cycle
      bus.in_valid = 1'b1; bus.op = 3'd7; bus.a = 32'hFFF03CFF; bus.en_mask = 4'hF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.f !== 8'hFF || bus.out_op !== 3'd7) begin
         bad++;
         $display("FAIL reset_preload: got v=%b f=%h op=%h, want v=1 f=ff op=7",
                  bus.out_valid, bus.f, bus.out_op);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.f !== '0 || bus.out_op !== 3'd0) begin
         bad++;
         $display("FAIL reset_async: got v=%b f=%h op=%h, want v=0 f=00 op=0",
                  bus.out_valid, bus.f, bus.out_op);
      end
      @(negedge clk); rst_n = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [2:0]     t_op   [10];
      logic [N*W-1:0] t_a    [10];
      logic [N-1:0]   t_m    [10];
      logic [W-1:0]   t_exp  [10];
      t_op = '{3'd0, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd2, 3'd1, 3'd4};
      t_a  = '{32'hFFF03CFF, 32'hFFF03CFF, 32'h01020408, 32'h01020408, 32'hFFF03CFF,
               32'hFFF03CFF, 32'hFFF03CFF, 32'hFFF03CFF, 32'h01020408, 32'h01020408};
      t_m  = '{4'hF, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
      t_exp = '{8'h30, 8'hFF, 8'h0A, 8'hF5, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h00};
      apply_reset();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = 1'b1; bus.op = t_op[k]; bus.a = t_a[k]; bus.en_mask = t_m[k];
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         total++;
         if (bus.out_valid !== 1'b1 || bus.f !== t_exp[k] || bus.out_op !== t_op[k]) begin
            bad++;
            $display("FAIL directed[%0d]: got v=%b f=%h op=%h, want v=1 f=%h op=%h",
                     k, bus.out_valid, bus.f, bus.out_op, t_exp[k], t_op[k]);
         end
      end
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL directed_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_f;
      apply_reset();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.op       = 3'(k);
         bus.a        = $urandom;
         bus.en_mask  = 4'($urandom);
         exp_f        = ref_gate(bus.op, bus.a, bus.en_mask);
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus.in_ready);
         end
         @(posedge clk); #1;
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_op !== 3'(k) || bus.f !== exp_f) begin
            bad++;
            $display("FAIL b2b_result[%0d]: got v=%b op=%h f=%h, want v=1 op=%h f=%h",
                     k, bus.out_valid, bus.out_op, bus.f, 3'(k), exp_f);
         end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] r1, r2;
      apply_reset();
      bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 32'h01020408; bus.en_mask = 4'hF;
      r1 = 8'h0F;
      @(posedge clk); #1;
      bus.op = 3'd0; bus.a = 32'hFFF03CFF; bus.en_mask = 4'hF;
      r2 = 8'h30;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.f !== r1 || bus.out_op !== 3'd1) begin
            bad++;
            $display("FAIL stall[%0d]: got rdy=%b v=%b f=%h op=%h, want rdy=0 v=1 f=%h op=1",
                     k, bus.in_ready, bus.out_valid, bus.f, bus.out_op, r1);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.f !== r1) begin
         bad++;
         $display("FAIL stall_release: got rdy=%b f=%h, want rdy=1 f=%h", bus.in_ready, bus.f, r1);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.f !== r2 || bus.out_op !== 3'd0) begin
         bad++;
         $display("FAIL stall_next: got v=%b f=%h op=%h, want v=1 f=%h op=0",
                  bus.out_valid, bus.f, bus.out_op, r2);
      end
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] sb_f  [$];
      logic [2:0]   sb_op [$];
      logic         exp_rdy, acc, pending;
      apply_reset();
      pending = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pending) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.op       = 3'($urandom);
            bus.a        = $urandom;
            bus.en_mask  = 4'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         exp_rdy = (sb_f.size() == 0) || bus.out_ready;
         total++;
         if (bus.in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rand_ready[%0d]: got %b want %b", cyc, bus.in_ready, exp_rdy);
         end
         total++;
         if (bus.out_valid !== (sb_f.size() != 0)) begin
            bad++;
            $display("FAIL rand_valid[%0d]: got %b want %b", cyc, bus.out_valid, sb_f.size() != 0);
         end else if (sb_f.size() != 0) begin
            total++;
            if (bus.f !== sb_f[0] || bus.out_op !== sb_op[0]) begin
               bad++;
               $display("FAIL rand_data[%0d]: got f=%h op=%h want f=%h op=%h",
                        cyc, bus.f, bus.out_op, sb_f[0], sb_op[0]);
            end
         end
         acc = bus.in_valid && exp_rdy;
         if (sb_f.size() != 0 && bus.out_ready) begin
            void'(sb_f.pop_front());
            void'(sb_op.pop_front());
         end
         if (acc) begin
            sb_f.push_back(ref_gate(bus.op, bus.a, bus.en_mask));
            sb_op.push_back(bus.op);
         end
         pending = bus.in_valid && !acc;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

`ifdef GATE_OPCNT_EN
   task automatic test_opcnt();
      logic [CNT_W-1:0] exp_cnt;
      apply_reset();
      total++;
      if (bus.op_cnt !== '0) begin
         bad++;
         $display("FAIL opcnt_reset: got %h want 0", bus.op_cnt);
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         bus.in_valid = 1'b1; bus.op = 3'($urandom); bus.a = $urandom; bus.en_mask = 4'($urandom);
         @(posedge clk); #1;
         exp_cnt = (k > 15) ? 4'hF : 4'(k);
         total++;
         if (bus.op_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL opcnt[%0d]: got %h want %h", k, bus.op_cnt, exp_cnt);
         end
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.op_cnt !== '0) begin
         bad++;
         $display("FAIL opcnt_clear: got %h want 0", bus.op_cnt);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
`ifdef GATE_OPCNT_EN
      test_opcnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
